// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and lane helpers for the load/store unit.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic load_f3_ok(input logic [2:0] f3);
      return !((f3 == 3'b011) || (f3[2:1] == 2'b11));
   endfunction

   function automatic logic store_f3_ok(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
   endfunction

   // funct3[1:0] encodes the access width for both signed and unsigned forms.
   function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b01:   return !off[0];
         2'b10:   return off == 2'b00;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b00:   return BE_B << off;
         2'b01:   return BE_H << {off[1], 1'b0};
         default: return BE_W;
      endcase
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (f3[1:0])
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/load_aligner.sv
// Picks the addressed byte/halfword out of a read word and sign- or zero-extends it.
module load_aligner
   import lsu_pkg::*;
(
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] load_ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = mem_rdata[{off, 3'b000} +: 8];
      half_sel = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3)
         F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_ext = {24'd0, byte_sel};
         F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_ext = {16'd0, half_sel};
         default: load_ext = mem_rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: request/ready handshake to data memory with
// alignment and funct3 checking, wait-cycle timeout, and load writeback strobe.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load_enb,
   input  logic        store_enb,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        stall,
   output logic        misaligned,
   output logic        bus_err
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   state_t         state_reg;
   logic [CW-1:0]  wait_cnt_reg;
   logic [1:0]     off_reg;
   logic [2:0]     f3_reg;
   logic [31:0]    aligned_data;

   logic op_req, is_store, f3_ok, addr_ok, accept;

   // A simultaneous load and store resolves to the load.
   assign op_req   = load_enb | store_enb;
   assign is_store = store_enb & ~load_enb;
   assign f3_ok    = load_enb ? load_f3_ok(funct3) : store_f3_ok(funct3);
   assign addr_ok  = is_aligned(funct3, addr[1:0]);
   assign accept   = (state_reg == IDLE) && op_req && f3_ok && addr_ok;
   assign stall    = accept || (state_reg == REQ);

   load_aligner u_aligner (
      .mem_rdata (mem_rdata),
      .off       (off_reg),
      .funct3    (f3_reg),
      .load_ext  (aligned_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= IDLE;
         wait_cnt_reg <= '0;
         off_reg      <= 2'd0;
         f3_reg       <= 3'd0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= 32'd0;
         mem_wdata    <= 32'd0;
         mem_be       <= 4'd0;
         load_data    <= 32'd0;
         load_valid   <= 1'b0;
         misaligned   <= 1'b0;
         bus_err      <= 1'b0;
      end else begin
         load_valid <= 1'b0;
         misaligned <= 1'b0;
         bus_err    <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (op_req) begin
                  if (!f3_ok) begin
                     bus_err <= 1'b1;
                  end else if (!addr_ok) begin
                     misaligned <= 1'b1;
                  end else begin
                     mem_req      <= 1'b1;
                     mem_we       <= is_store;
                     mem_addr     <= {addr[31:2], 2'b00};
                     mem_wdata    <= lane_wdata(funct3, store_data);
                     mem_be       <= lane_be(funct3, addr[1:0]);
                     off_reg      <= addr[1:0];
                     f3_reg       <= funct3;
                     wait_cnt_reg <= '0;
                     state_reg    <= REQ;
                  end
               end
            end
            REQ: begin
               // Ready on the same cycle the counter hits TIMEOUT still completes.
               if (mem_ready) begin
                  mem_req    <= 1'b0;
                  load_valid <= !mem_we;
                  if (!mem_we) begin
                     load_data <= aligned_data;
                  end
                  state_reg <= DONE;
               end else if (wait_cnt_reg == CW'(TIMEOUT)) begin
                  mem_req   <= 1'b0;
                  bus_err   <= 1'b1;
                  state_reg <= IDLE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected bus accesses and results are
// queued at issue time and matched when the DUT handshakes or pulses.
module tb_load_store_unit;

   localparam int K_LOAD = 0;
   localparam int K_MIS  = 1;
   localparam int K_ERR  = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        load_enb = 1'b0;
   logic        store_enb = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] store_data = 32'd0;
   logic        mem_ready = 1'b0;
   logic [31:0] mem_rdata = 32'd0;
   logic        mem_req, mem_we, load_valid, stall, misaligned, bus_err;
   logic [31:0] mem_addr, mem_wdata, load_data;
   logic [3:0]  mem_be;

   load_store_unit #(.TIMEOUT(15)) dut (
      .clk        (clk),
      .reset      (reset),
      .load_enb   (load_enb),
      .store_enb  (store_enb),
      .funct3     (funct3),
      .addr       (addr),
      .store_data (store_data),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .load_data  (load_data),
      .load_valid (load_valid),
      .stall      (stall),
      .misaligned (misaligned),
      .bus_err    (bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   typedef struct {
      int          kind;
      logic [31:0] data;
   } res_t;

   bus_t bus_q[$];
   res_t res_q[$];

   int checks = 0;
   int errors = 0;
   int ready_delay = 0;
   int req_age = 0;
   int req_seen = 0;
   logic [31:0] last_load_exp = 32'd0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Memory responder: ready after ready_delay REQ cycles.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (mem_req) begin
            mem_ready = (req_age == ready_delay);
            req_age++;
         end else begin
            mem_ready = 1'b0;
            req_age = 0;
         end
      end
   end

   // Output monitor.
   always @(negedge clk) begin
      if (reset) begin
         bus_t b;
         res_t r;
         int obs_kind;
         int n_pulse;
         if (mem_req) req_seen++;
         if (mem_req && mem_ready) begin
            if (bus_q.size() == 0) begin
               check_eq("bus_unexp", {31'd0, mem_ready}, 32'd0);
            end else begin
               b = bus_q.pop_front();
               check_eq("bus_addr", mem_addr, b.addr);
               check_eq("bus_we", {31'd0, mem_we}, {31'd0, b.we});
               check_eq("bus_be", {28'd0, mem_be}, {28'd0, b.be});
               if (b.we) check_eq("bus_wdata", mem_wdata, b.wdata);
            end
         end
         n_pulse = int'(load_valid) + int'(misaligned) + int'(bus_err);
         if (n_pulse != 0) begin
            check_eq("pulse_excl", n_pulse, 1);
            obs_kind = load_valid ? K_LOAD : (misaligned ? K_MIS : K_ERR);
            if (res_q.size() == 0) begin
               check_eq("res_unexp", {29'd0, load_valid, misaligned, bus_err}, 32'd0);
            end else begin
               r = res_q.pop_front();
               check_eq("res_kind", obs_kind, r.kind);
               if (load_valid) check_eq("load_data", load_data, r.data);
            end
         end
      end
   end

   // Reference model: queue what a request must produce; returns expected stall.
   task automatic expect_op(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] rd, output logic acc);
      logic is_ld, is_st, legal, mis;
      logic [31:0] sh;
      logic [15:0] hw;
      bus_t b;
      res_t r;
      is_ld = ld;
      is_st = st && !ld;
      legal = is_ld ? !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) : (f3 <= 3'd2);
      mis   = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
      acc   = 1'b0;
      if (!is_ld && !is_st) return;
      if (!legal) begin
         r.kind = K_ERR; r.data = 32'd0; res_q.push_back(r);
      end else if (mis) begin
         r.kind = K_MIS; r.data = 32'd0; res_q.push_back(r);
      end else begin
         acc = 1'b1;
         b.addr = a & 32'hFFFF_FFFC;
         b.we = is_st;
         case (f3[1:0])
            2'b00:   begin b.be = 4'b0001 << a[1:0]; b.wdata = {4{d[7:0]}}; end
            2'b01:   begin b.be = a[1] ? 4'b1100 : 4'b0011; b.wdata = {2{d[15:0]}}; end
            default: begin b.be = 4'b1111; b.wdata = d; end
         endcase
         bus_q.push_back(b);
         if (is_ld) begin
            sh = rd >> (8 * int'(a[1:0]));
            hw = a[1] ? rd[31:16] : rd[15:0];
            case (f3)
               3'd0:    r.data = {{24{sh[7]}}, sh[7:0]};
               3'd4:    r.data = {24'd0, sh[7:0]};
               3'd1:    r.data = {{16{hw[15]}}, hw};
               3'd5:    r.data = {16'd0, hw};
               default: r.data = rd;
            endcase
            r.kind = K_LOAD;
            last_load_exp = r.data;
            res_q.push_back(r);
         end
      end
   endtask

   // Drive one request (called just after a rising edge) and wait until back in IDLE.
   task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd, input int dly);
      logic acc;
      int n;
      mem_rdata = rd;
      ready_delay = dly;
      expect_op(ld, st, f3, a, d, rd, acc);
      load_enb = ld; store_enb = st; funct3 = f3; addr = a; store_data = d;
      @(negedge clk);
      check_eq("stall_issue", {31'd0, stall}, {31'd0, acc});
      @(posedge clk); #1;
      load_enb = 1'b0; store_enb = 1'b0;
      n = 0;
      while (stall && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 60) check_eq("op_bound", n, 0);
      @(posedge clk); #1;
      $display("op ld=%0b st=%0b f3=%0d addr=%h data=%h rdata=%h delay=%0d",
               ld, st, f3, a, d, rd, dly);
   endtask

   initial begin
      logic acc;
      int n_req, n, seen0;
      logic saw_err;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
      check_eq("rst_mem_addr", mem_addr, 32'd0);
      check_eq("rst_mem_wdata", mem_wdata, 32'd0);
      check_eq("rst_mem_be", {28'd0, mem_be}, 32'd0);
      check_eq("rst_load_data", load_data, 32'd0);
      check_eq("rst_flags", {28'd0, load_valid, misaligned, bus_err, stall}, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // LW latency with ready tied high.
      ready_delay = 0;
      mem_rdata = 32'hDEADBEEF;
      expect_op(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, acc);
      load_enb = 1'b1; funct3 = 3'b010; addr = 32'h100;
      @(negedge clk);
      check_eq("lw_c0_stall", {31'd0, stall}, 32'd1);
      check_eq("lw_c0_req", {31'd0, mem_req}, 32'd0);
      @(posedge clk); #1;
      load_enb = 1'b0;
      @(negedge clk);
      check_eq("lw_c1_req", {31'd0, mem_req}, 32'd1);
      check_eq("lw_c1_stall", {31'd0, stall}, 32'd1);
      check_eq("lw_c1_addr", mem_addr, 32'h100);
      check_eq("lw_c1_be", {28'd0, mem_be}, 32'hF);
      @(negedge clk);
      check_eq("lw_c2_valid", {31'd0, load_valid}, 32'd1);
      check_eq("lw_c2_stall", {31'd0, stall}, 32'd0);
      check_eq("lw_c2_data", load_data, 32'hDEADBEEF);
      @(posedge clk); #1;
      $display("op LW addr=00000100 latency test");

      // Byte loads, signed then unsigned.
      run_op(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF1234, 0);
      check_eq("lb_result", load_data, 32'hFFFFFF80);
      run_op(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF1234, 0);
      check_eq("lbu_result", load_data, 32'h00000080);

      // Halfword store to upper lane.
      run_op(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000ABCD, 32'd0, 1);

      // Misaligned word load: no bus request, no stall.
      seen0 = req_seen;
      run_op(1'b1, 1'b0, 3'b010, 32'h101, 32'd0, 32'd0, 0);
      check_eq("mis_no_req", req_seen - seen0, 0);

      // Illegal funct3 for load and store; both enables resolve to a load.
      run_op(1'b1, 1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 0);
      run_op(1'b0, 1'b1, 3'b100, 32'h10, 32'h55, 32'd0, 0);
      run_op(1'b1, 1'b1, 3'b010, 32'h500, 32'h12345678, 32'hCAFEF00D, 0);

      // Timeout: 16 REQ cycles then bus_err, load_data unchanged.
      begin
         res_t r;
         r.kind = K_ERR; r.data = 32'd0;
         res_q.push_back(r);
      end
      ready_delay = 255;
      load_enb = 1'b1; funct3 = 3'b010; addr = 32'h300;
      @(posedge clk); #1;
      load_enb = 1'b0;
      n_req = 0; saw_err = 1'b0; n = 0;
      while (!saw_err && n < 40) begin
         @(negedge clk);
         if (mem_req) n_req++;
         if (bus_err) saw_err = 1'b1;
         n++;
      end
      check_eq("to_err_seen", {31'd0, saw_err}, 32'd1);
      check_eq("to_req_cycles", n_req, 16);
      check_eq("to_stall", {31'd0, stall}, 32'd0);
      check_eq("to_load_data", load_data, last_load_exp);
      @(posedge clk); #1;
      $display("op LW addr=00000300 timeout test");

      // Ready on the 16th REQ cycle completes without error.
      run_op(1'b1, 1'b0, 3'b101, 32'h302, 32'd0, 32'h8001_7FFF, 15);
      check_eq("late_ready_data", load_data, 32'h00008001);

      // Reset asserted in the 3rd REQ cycle drops mem_req without a clock edge.
      ready_delay = 255;
      load_enb = 1'b1; funct3 = 3'b010; addr = 32'h400;
      @(posedge clk); #1;
      load_enb = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_eq("rstmid_req_before", {31'd0, mem_req}, 32'd1);
      #1 reset = 1'b0;
      #1;
      check_eq("rstmid_req_after", {31'd0, mem_req}, 32'd0);
      check_eq("rstmid_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      $display("op LW addr=00000400 reset mid-access");
      run_op(1'b1, 1'b0, 3'b010, 32'h104, 32'd0, 32'h0BADF00D, 0);

      // Random mix.
      for (int i = 0; i < 30; i++) begin
         logic ld, st;
         logic [2:0] f3;
         logic [31:0] a;
         ld = 1'($urandom_range(0, 1));
         st = ld ? 1'($urandom_range(0, 1)) : 1'b1;
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         run_op(ld, st, f3, a, $urandom, $urandom, int'($urandom_range(0, 3)));
      end

      repeat (3) @(posedge clk);
      #1;
      check_eq("bus_q_drained", bus_q.size(), 0);
      check_eq("res_q_drained", res_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
